instrument_mem_arbiter: RTL and testbench
=========================================

# instrument_mem_arbiter

Two-port Avalon-MM arbiter that shares the single SDRAM command port of the InstrumentUnit memory subsystem between two requesters: the spacecraft core (port 0) and the instrument capture DMA (port 1). It arbitrates single-beat reads and writes, tracks outstanding pipelined reads in an ID FIFO, and routes each returning read beat to its originator. It sits between the requesters and the memory controller's Avalon slave. A 4-bit status word is exported for the spacecraft LED readback.

## Interface

- ADDR_W, 26, word address width
- DATA_W, 32, data width; byteenable width is DATA_W/8
- MAX_OUTSTANDING, 8, read-ID FIFO depth; power of two, minimum 2

- clk_clk  in  1  system clock; all logic on rising edge
- reset_reset_n  in  1  synchronous, active-low reset
- rN_address  in  ADDR_W  requester N address (N = 0, 1)
- rN_read, rN_write  in  1  requester N command strobes; never both high
- rN_writedata  in  DATA_W  requester N write data
- rN_byteenable  in  DATA_W/8  requester N byte enables
- rN_waitrequest  out  1  low only in the cycle requester N's command is accepted
- rN_readdata  out  DATA_W  returned read data, registered
- rN_readdatavalid  out  1  one-cycle read-return strobe
- m_address, m_writedata, m_byteenable  out  as above  memory command fields
- m_read, m_write  out  1  memory command strobes
- m_waitrequest  in  1  memory stall
- m_readdata  in  DATA_W  memory read data
- m_readdatavalid  in  1  memory read-return strobe
- arb_status  out  4  {orphan_err, fifo_full, state[1:0]}

## Operation

- FSM states: IDLE (2'b00), GRANT0 (2'b01), GRANT1 (2'b10).
- IDLE: a requester is eligible if it asserts write, or asserts read while the FIFO is not full. With one eligible requester, go to its GRANT state. With both eligible, round-robin: grant the one not in last_grant. last_grant resets to 1, so port 0 wins the first tie.
- GRANTn: the m_* command fields and strobes are muxed combinationally from requester n; they are held while m_waitrequest=1.
- Acceptance happens when m_read|m_write is high and m_waitrequest=0. In that cycle, rn_waitrequest=0, last_grant<=n, and the next state is IDLE.
- If requester n drops its strobe while granted (a protocol violation), the FSM returns to IDLE without issuing a command.
- Accepted read: push n into the ID FIFO.
- m_readdatavalid: pop the FIFO head h. Next cycle, rh_readdatavalid=1 and rh_readdata=m_readdata. The other port's valid stays 0.
- A simultaneous push and pop leaves the occupancy unchanged.
- FIFO full: reads are ineligible; writes are still granted.
- m_readdatavalid with an empty FIFO: the beat is dropped and orphan_err sets. orphan_err is sticky until reset.
- Reset mid-operation:
  - FSM returns to IDLE and the FIFO is cleared.
  - Reads in flight when reset asserts come back as orphans, setting orphan_err.

## Timing

- Reset values:
  - all rN_waitrequest = 1
  - rN_readdatavalid = 0, rN_readdata = 0
  - m_read = m_write = 0
  - arb_status = 4'b0000
- Command latency: request seen in IDLE at cycle T; m_* driven at T+1. With m_waitrequest=0, acceptance is at T+1 and the FSM is back in IDLE at T+2.
- Peak throughput is one command per 2 cycles.
- Read return latency: m_readdatavalid at cycle M gives rN_readdatavalid at M+1.
- Returns are delivered in issue order. Back-to-back return beats are supported at 1 per cycle.
- fifo_full reflects the registered occupancy: 1 when count == MAX_OUTSTANDING.

## Configuration

- INSTR_ARB_FIXED_PRIO_EN defined: fixed priority, port 0 always wins ties; last_grant is unused.
- INSTR_ARB_FIXED_PRIO_EN undefined (default): round-robin as described above.

## Test plan

- Single read, port 0: addr 0x100, memory returns 0xDEADBEEF three cycles after acceptance → r0_readdatavalid one cycle later with 0xDEADBEEF; r1_readdatavalid stays 0.
- Contention: both ports hold writes continuously → grants alternate 0,1,0,1 under round-robin; with INSTR_ARB_FIXED_PRIO_EN, only port 0 is granted while it keeps requesting.
- Stall: m_waitrequest held 1 for 5 cycles during GRANT1 → m_* stable for all 5 cycles, r1_waitrequest=1 throughout, and acceptance on the 6th cycle.
- Outstanding limit, MAX_OUTSTANDING=8, no returns: 8 reads accepted, then fifo_full=1 and a 9th read is not granted while a port-1 write still is; one return then unblocks the read.
- Interleaved returns: reads issued 0,1,1,0 with data 0xA,0xB,0xC,0xD → port 0 receives 0xA then 0xD, port 1 receives 0xB then 0xC.
- Orphan and reset: reset_reset_n low for 1 cycle with 2 reads in flight, then 2 returns → no rN_readdatavalid, and arb_status[3]=1 until the next reset.

Source files
------------

// File: rtl/instrument_mem_arbiter.sv
// Two-port Avalon-MM arbiter sharing one memory command port, with in-order read-return routing.
// Define INSTR_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins ties); default build is round-robin.
module instrument_mem_arbiter #(
    parameter int ADDR_W          = 26,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                clk_clk,
    input  logic                reset_reset_n,
    input  logic [ADDR_W-1:0]   r0_address,
    input  logic                r0_read,
    input  logic                r0_write,
    input  logic [DATA_W-1:0]   r0_writedata,
    input  logic [DATA_W/8-1:0] r0_byteenable,
    output logic                r0_waitrequest,
    output logic [DATA_W-1:0]   r0_readdata,
    output logic                r0_readdatavalid,
    input  logic [ADDR_W-1:0]   r1_address,
    input  logic                r1_read,
    input  logic                r1_write,
    input  logic [DATA_W-1:0]   r1_writedata,
    input  logic [DATA_W/8-1:0] r1_byteenable,
    output logic                r1_waitrequest,
    output logic [DATA_W-1:0]   r1_readdata,
    output logic                r1_readdatavalid,
    output logic [ADDR_W-1:0]   m_address,
    output logic [DATA_W-1:0]   m_writedata,
    output logic [DATA_W/8-1:0] m_byteenable,
    output logic                m_read,
    output logic                m_write,
    input  logic                m_waitrequest,
    input  logic [DATA_W-1:0]   m_readdata,
    input  logic                m_readdatavalid,
    output logic [3:0]          arb_status
);
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE = 2'b00, GRANT0 = 2'b01, GRANT1 = 2'b10} state_t;

    state_t            state_reg;
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic              id_mem [MAX_OUTSTANDING];
    logic              orphan_err_reg;
    logic [1:0]        rvalid_reg;
    logic [DATA_W-1:0] rdata_reg [2];

    logic       fifo_full;
    logic       fifo_empty;
    logic       elig0;
    logic       elig1;
    logic       grant1_sel;
    logic       accept;
    logic       push;
    logic       pop;
    logic       head_id;
    logic [1:0] ret_hit;

    assign fifo_full  = (count_reg == CNT_W'(MAX_OUTSTANDING));
    assign fifo_empty = (count_reg == '0);
    assign elig0      = r0_write | (r0_read & ~fifo_full);
    assign elig1      = r1_write | (r1_read & ~fifo_full);

`ifdef INSTR_ARB_FIXED_PRIO_EN
    assign grant1_sel = elig1 & ~elig0;
`else
    logic last_grant_reg;
    // On a tie, port 1 wins only if port 0 was the last one served.
    assign grant1_sel = elig1 & (~elig0 | ~last_grant_reg);
`endif

    always_comb begin
        m_address    = r0_address;
        m_writedata  = r0_writedata;
        m_byteenable = r0_byteenable;
        m_read       = 1'b0;
        m_write      = 1'b0;
        case (state_reg)
            GRANT0: begin
                m_read  = r0_read & ~fifo_full;
                m_write = r0_write;
            end
            GRANT1: begin
                m_address    = r1_address;
                m_writedata  = r1_writedata;
                m_byteenable = r1_byteenable;
                m_read       = r1_read & ~fifo_full;
                m_write      = r1_write;
            end
            default: ;
        endcase
    end

    assign accept         = (m_read | m_write) & ~m_waitrequest;
    assign r0_waitrequest = ~(accept & (state_reg == GRANT0));
    assign r1_waitrequest = ~(accept & (state_reg == GRANT1));
    assign push           = accept & m_read;
    assign pop            = m_readdatavalid & ~fifo_empty;
    assign head_id        = id_mem[rd_ptr_reg];

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state_reg <= IDLE;
`ifndef INSTR_ARB_FIXED_PRIO_EN
            last_grant_reg <= 1'b1;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (elig0 | elig1)
                        state_reg <= grant1_sel ? GRANT1 : GRANT0;
                end
                GRANT0, GRANT1: begin
                    if (accept) begin
                        state_reg <= IDLE;
`ifndef INSTR_ARB_FIXED_PRIO_EN
                        last_grant_reg <= (state_reg == GRANT1);
`endif
                    end else if (!(m_read | m_write)) begin
                        // Requester withdrew its strobe: abandon the grant without a command.
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk_clk) begin
        if (push)
            id_mem[wr_ptr_reg] <= (state_reg == GRANT1);
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ret
            assign ret_hit[gi] = pop & ((gi == 1) ? head_id : ~head_id);
        end
    endgenerate

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            rvalid_reg     <= '0;
            rdata_reg[0]   <= '0;
            rdata_reg[1]   <= '0;
            orphan_err_reg <= 1'b0;
        end else begin
            rvalid_reg <= ret_hit;
            for (int i = 0; i < 2; i++) begin
                if (ret_hit[i])
                    rdata_reg[i] <= m_readdata;
            end
            if (m_readdatavalid && fifo_empty)
                orphan_err_reg <= 1'b1;
        end
    end

    assign r0_readdatavalid = rvalid_reg[0];
    assign r1_readdatavalid = rvalid_reg[1];
    assign r0_readdata      = rdata_reg[0];
    assign r1_readdata      = rdata_reg[1];
    assign arb_status       = {orphan_err_reg, fifo_full, state_reg};

endmodule

// File: tb/tb_instrument_mem_arbiter.sv
// Bench for instrument_mem_arbiter: directed scenarios plus randomized traffic checked
// against an in-order return scoreboard (queue of expected port/data pairs).
module tb_instrument_mem_arbiter;
    localparam int ADDR_W  = 26;
    localparam int DATA_W  = 32;
    localparam int MAX_OUT = 8;

    logic                clk_clk = 1'b0;
    logic                reset_reset_n;
    logic [ADDR_W-1:0]   r0_address, r1_address, m_address;
    logic                r0_read, r0_write, r1_read, r1_write;
    logic [DATA_W-1:0]   r0_writedata, r1_writedata, m_writedata;
    logic [DATA_W/8-1:0] r0_byteenable, r1_byteenable, m_byteenable;
    logic                r0_waitrequest, r1_waitrequest;
    logic [DATA_W-1:0]   r0_readdata, r1_readdata, m_readdata;
    logic                r0_readdatavalid, r1_readdatavalid;
    logic                m_read, m_write, m_waitrequest, m_readdatavalid;
    logic [3:0]          arb_status;

    always #5 clk_clk = ~clk_clk;

    instrument_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUTSTANDING(MAX_OUT)) dut (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
        .r0_address(r0_address), .r0_read(r0_read), .r0_write(r0_write),
        .r0_writedata(r0_writedata), .r0_byteenable(r0_byteenable),
        .r0_waitrequest(r0_waitrequest), .r0_readdata(r0_readdata), .r0_readdatavalid(r0_readdatavalid),
        .r1_address(r1_address), .r1_read(r1_read), .r1_write(r1_write),
        .r1_writedata(r1_writedata), .r1_byteenable(r1_byteenable),
        .r1_waitrequest(r1_waitrequest), .r1_readdata(r1_readdata), .r1_readdatavalid(r1_readdatavalid),
        .m_address(m_address), .m_writedata(m_writedata), .m_byteenable(m_byteenable),
        .m_read(m_read), .m_write(m_write), .m_waitrequest(m_waitrequest),
        .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid), .arb_status(arb_status)
    );

    typedef struct packed {
        logic              port;
        logic [DATA_W-1:0] data;
    } ret_t;

    int checks = 0;
    int failures = 0;

    ret_t              pend_q[$];
    ret_t              ret;
    int                grants[$];
    int                exp_g;
    bit                acc0, acc1;
    bit                acc[2];
    bit                req_act[2];
    bit                req_wr[2];
    logic [ADDR_W-1:0] req_addr[2];
    logic [DATA_W-1:0] req_data[2];
    bit                exp_v[2];
    logic [DATA_W-1:0] exp_d[2];
    int                il_port[4] = '{0, 1, 1, 0};

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk_clk);
    endtask

    task automatic set_req(input int p, input logic rd, input logic wr,
                           input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        if (p == 0) begin
            r0_read = rd; r0_write = wr; r0_address = a; r0_writedata = d; r0_byteenable = a[3:0];
        end else begin
            r1_read = rd; r1_write = wr; r1_address = a; r1_writedata = d; r1_byteenable = a[3:0];
        end
    endtask

    task automatic do_reset();
        reset_reset_n = 1'b0;
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        m_waitrequest = 1'b0;
        m_readdatavalid = 1'b0;
        m_readdata = '0;
        tick();
        tick();
        reset_reset_n = 1'b1;
    endtask

    // Hold a single command until the arbiter accepts it, then withdraw it.
    task automatic issue(input int p, input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bit done;
        done = 1'b0;
        set_req(p, ~wr, wr, a, d);
        for (int k = 0; k < 30 && !done; k++) begin
            sample();
            if ((p == 0) ? !r0_waitrequest : !r1_waitrequest) begin
                done = 1'b1;
                check_eq("issue_addr", m_address, a);
                check_eq("issue_be", m_byteenable, a[3:0]);
                check_eq("issue_rw", {m_read, m_write}, {~wr, wr});
                $display("issue port=%0d %s addr=%h", p, wr ? "write" : "read", a);
            end
            tick();
        end
        check_eq("issue_accepted", done, 1);
        set_req(p, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        do_reset();
        sample();
        check_eq("rst_wait0", r0_waitrequest, 1);
        check_eq("rst_wait1", r1_waitrequest, 1);
        check_eq("rst_rdv0", r0_readdatavalid, 0);
        check_eq("rst_rdv1", r1_readdatavalid, 0);
        check_eq("rst_rdata0", r0_readdata, 0);
        check_eq("rst_rdata1", r1_readdata, 0);
        check_eq("rst_mcmd", {m_read, m_write}, 0);
        check_eq("rst_status", arb_status, 4'b0000);

        // Single read on port 0 with command-latency checks
        tick();
        set_req(0, 1'b1, 1'b0, 26'h100, '0);
        sample();
        check_eq("lat_idle_mread", m_read, 0);
        check_eq("lat_idle_wait0", r0_waitrequest, 1);
        sample();
        check_eq("lat_grant_mread", m_read, 1);
        check_eq("lat_grant_addr", m_address, 26'h100);
        check_eq("lat_grant_wait0", r0_waitrequest, 0);
        check_eq("lat_grant_state", arb_status[1:0], 2'b01);
        tick();
        set_req(0, 1'b0, 1'b0, '0, '0);
        sample();
        check_eq("lat_back_idle", arb_status[1:0], 2'b00);
        tick();
        tick();
        m_readdatavalid = 1'b1;
        m_readdata = 32'hDEADBEEF;
        sample();
        check_eq("ret_early_v0", r0_readdatavalid, 0);
        tick();
        m_readdatavalid = 1'b0;
        m_readdata = '0;
        sample();
        check_eq("ret_v0", r0_readdatavalid, 1);
        check_eq("ret_d0", r0_readdata, 32'hDEADBEEF);
        check_eq("ret_v1", r1_readdatavalid, 0);
        $display("return port=0 data=%h", r0_readdata);
        sample();
        check_eq("ret_v0_once", r0_readdatavalid, 0);

        // Contention: both ports hold writes continuously
        do_reset();
        set_req(0, 1'b0, 1'b1, 26'h10, 32'h1000);
        set_req(1, 1'b0, 1'b1, 26'h20, 32'h2000);
        for (int k = 0; k < 40 && grants.size() < 6; k++) begin
            sample();
            if (!r0_waitrequest) begin
                grants.push_back(0);
                check_eq("cont_wdata0", m_writedata, 32'h1000);
            end
            if (!r1_waitrequest) begin
                grants.push_back(1);
                check_eq("cont_wdata1", m_writedata, 32'h2000);
            end
            tick();
        end
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        check_eq("cont_count", grants.size(), 6);
        foreach (grants[i]) begin
`ifdef INSTR_ARB_FIXED_PRIO_EN
            exp_g = 0;
`else
            exp_g = i % 2;
`endif
            check_eq("cont_order", grants[i], exp_g);
            $display("grant %0d -> port %0d", i, grants[i]);
        end

        // Stall: port 1 granted while memory waitrequests for 5 cycles
        do_reset();
        m_waitrequest = 1'b1;
        set_req(1, 1'b0, 1'b1, 26'h3A5, 32'hCAFE0001);
        sample();
        for (int k = 0; k < 5; k++) begin
            sample();
            check_eq("stall_mwrite", m_write, 1);
            check_eq("stall_addr", m_address, 26'h3A5);
            check_eq("stall_wdata", m_writedata, 32'hCAFE0001);
            check_eq("stall_be", m_byteenable, 4'h5);
            check_eq("stall_wait1", r1_waitrequest, 1);
            check_eq("stall_state", arb_status[1:0], 2'b10);
        end
        tick();
        m_waitrequest = 1'b0;
        sample();
        check_eq("stall_accept", r1_waitrequest, 0);
        check_eq("stall_accept_addr", m_address, 26'h3A5);
        tick();
        set_req(1, 1'b0, 1'b0, '0, '0);

        // Outstanding limit: fill the ID FIFO with port-0 reads
        do_reset();
        for (int i = 0; i < MAX_OUT; i++)
            issue(0, 1'b0, 26'(i * 4 + 'h40), '0);
        set_req(0, 1'b1, 1'b0, 26'h200, '0);
        set_req(1, 1'b0, 1'b1, 26'h300, 32'h33);
        sample();
        check_eq("full_flag", arb_status[2], 1);
        acc0 = 1'b0;
        acc1 = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (!r0_waitrequest) acc0 = 1'b1;
            if (!r1_waitrequest) acc1 = 1'b1;
            tick();
            if (acc1) set_req(1, 1'b0, 1'b0, '0, '0);
            sample();
        end
        check_eq("full_read_blocked", acc0, 0);
        check_eq("full_write_granted", acc1, 1);
        tick();
        m_readdatavalid = 1'b1;
        m_readdata = 32'h5A5A5A5A;
        sample();
        tick();
        m_readdatavalid = 1'b0;
        sample();
        check_eq("full_ret_v0", r0_readdatavalid, 1);
        check_eq("full_ret_d0", r0_readdata, 32'h5A5A5A5A);
        for (int k = 0; k < 8 && !acc0; k++) begin
            if (!r0_waitrequest) begin
                acc0 = 1'b1;
            end else begin
                tick();
                sample();
            end
        end
        check_eq("full_unblock_read", acc0, 1);
        tick();
        set_req(0, 1'b0, 1'b0, '0, '0);

        // Interleaved returns routed by issue order
        do_reset();
        for (int i = 0; i < 4; i++)
            issue(il_port[i], 1'b0, 26'(i * 4 + 'h500), '0);
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                m_readdatavalid = 1'b1;
                m_readdata = 32'(10 + i);
            end else begin
                m_readdatavalid = 1'b0;
            end
            sample();
            if (i > 0) begin
                check_eq("ilv_v0", r0_readdatavalid, il_port[i-1] == 0);
                check_eq("ilv_v1", r1_readdatavalid, il_port[i-1] == 1);
                check_eq("ilv_data", (il_port[i-1] == 1) ? r1_readdata : r0_readdata, 32'(10 + i - 1));
                $display("return port=%0d data=%h", il_port[i-1], (il_port[i-1] == 1) ? r1_readdata : r0_readdata);
            end
            tick();
        end

        // Orphans: reset with two reads in flight, then two returns
        do_reset();
        issue(0, 1'b0, 26'h600, '0);
        issue(1, 1'b0, 26'h604, '0);
        reset_reset_n = 1'b0;
        tick();
        reset_reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            m_readdatavalid = (i < 2);
            m_readdata = 32'(32'h77 + i);
            sample();
            check_eq("orph_v0", r0_readdatavalid, 0);
            check_eq("orph_v1", r1_readdatavalid, 0);
            if (i >= 1) check_eq("orph_flag", arb_status[3], 1);
            tick();
        end
        do_reset();
        sample();
        check_eq("orph_cleared", arb_status, 4'b0000);
        tick();

        // Randomized traffic against the return scoreboard
        do_reset();
        pend_q.delete();
        for (int p = 0; p < 2; p++) begin
            req_act[p] = 1'b0;
            exp_v[p] = 1'b0;
            exp_d[p] = '0;
        end
        for (int cyc = 0; cyc < 800; cyc++) begin
            sample();
            check_eq("rnd_v0", r0_readdatavalid, exp_v[0]);
            check_eq("rnd_v1", r1_readdatavalid, exp_v[1]);
            for (int p = 0; p < 2; p++) begin
                if (exp_v[p]) begin
                    check_eq("rnd_data", (p == 1) ? r1_readdata : r0_readdata, exp_d[p]);
                    $display("rnd return port=%0d data=%h", p, exp_d[p]);
                end
            end
            check_eq("rnd_full", arb_status[2], pend_q.size() == MAX_OUT);
            exp_v[0] = 1'b0;
            exp_v[1] = 1'b0;
            if (m_readdatavalid) begin
                ret = pend_q.pop_front();
                exp_v[ret.port] = 1'b1;
                exp_d[ret.port] = ret.data;
            end
            acc[0] = req_act[0] && !r0_waitrequest;
            acc[1] = req_act[1] && !r1_waitrequest;
            check_eq("rnd_one_grant", acc[0] & acc[1], 0);
            for (int p = 0; p < 2; p++) begin
                if (!req_act[p])
                    check_eq("rnd_idle_wait", (p == 1) ? r1_waitrequest : r0_waitrequest, 1);
                if (acc[p]) begin
                    check_eq("rnd_addr", m_address, req_addr[p]);
                    check_eq("rnd_rw", {m_read, m_write}, {~req_wr[p], req_wr[p]});
                    if (req_wr[p]) begin
                        check_eq("rnd_wdata", m_writedata, req_data[p]);
                    end else begin
                        ret.port = (p == 1);
                        ret.data = $urandom;
                        pend_q.push_back(ret);
                    end
                end
            end
            tick();
            for (int p = 0; p < 2; p++) begin
                if (acc[p] || !req_act[p]) begin
                    if ($urandom_range(0, 2) != 0) begin
                        req_act[p]  = 1'b1;
                        req_wr[p]   = ($urandom_range(0, 1) == 1);
                        req_addr[p] = 26'($urandom);
                        req_data[p] = $urandom;
                        set_req(p, ~req_wr[p], req_wr[p], req_addr[p], req_data[p]);
                    end else begin
                        req_act[p] = 1'b0;
                        set_req(p, 1'b0, 1'b0, '0, '0);
                    end
                end
            end
            m_waitrequest = ($urandom_range(0, 3) == 0);
            if (pend_q.size() != 0 && $urandom_range(0, 1) == 1) begin
                m_readdatavalid = 1'b1;
                m_readdata = pend_q[0].data;
            end else begin
                m_readdatavalid = 1'b0;
                m_readdata = '0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
